axi_wr_arbiter: RTL and testbench
=================================

// Module: axi_wr_arbiter
// PURPOSE
//  Round-robin write-channel arbiter: shares one AXI write slave port (AW/W/B) among NB_MASTER write masters.
//  Allows one burst in flight at a time, from AW grant to B handshake.
//  Sits in front of a single-port slave, e.g. a peripheral bridge, where the full crossbar is too costly.
//  Slave-side ID = {master index, master ID}, so B routing and slave logs identify the requester.
// PARAMETERS
//  NB_MASTER   2    number of requesting masters (>=2)
//  ADDR_W      32   AW address width
//  DATA_W      64   W data width; strobe width DATA_W/8
//  ID_W        1    master-side ID width
//  SLV_ID_W    ID_W+$clog2(NB_MASTER)   slave-side ID width (derived, not overridable)
// PORTS
//  clk            in   1                    clock
//  rst            in   1                    synchronous reset, active-high
//  m_aw_valid     in   NB_MASTER            per-master AW valid
//  m_aw_ready     out  NB_MASTER            per-master AW ready
//  m_aw_addr      in   NB_MASTER x ADDR_W   per-master AW address
//  m_aw_len       in   NB_MASTER x 8        per-master burst length-1
//  m_aw_id        in   NB_MASTER x ID_W     per-master AW ID
//  m_w_valid/m_w_ready/m_w_last  in/out/in  NB_MASTER   per-master W handshake and last
//  m_w_data       in   NB_MASTER x DATA_W   W data
//  m_w_strb       in   NB_MASTER x DATA_W/8 W strobes
//  m_b_valid      out  NB_MASTER            B valid, routed
//  m_b_ready      in   NB_MASTER            B ready
//  m_b_resp       out  2                    B response, broadcast
//  m_b_id         out  ID_W                 B ID, broadcast; low bits of s_b_id
//  s_aw_valid/ready, s_aw_addr, s_aw_len, s_aw_id(SLV_ID_W)   slave AW
//  s_w_valid/ready, s_w_data, s_w_strb, s_w_last              slave W
//  s_b_valid/ready, s_b_resp(2), s_b_id(SLV_ID_W)             slave B
//  busy_o         out  1                    state != IDLE
//  proto_err_o    out  1                    one-cycle pulse on a protocol violation
// BEHAVIOUR
//  FSM states: IDLE -> ADDR -> DATA -> RESP -> IDLE. Registers: state, grant idx g, beat counter cnt[7:0], last_grant.
//  Reset: state=IDLE, last_grant=NB_MASTER-1 (master 0 wins first), cnt=0, proto_err_o=0.
//   In IDLE, all valid/ready outputs are 0 and busy_o=0.
//  IDLE: if any m_aw_valid, pick the first set bit scanning from last_grant+1 with wrap. Register g; go to ADDR.
//   Arbitration latency is 1 cycle, and no output is granted combinationally in IDLE.
//  ADDR: s_aw_valid=m_aw_valid[g]; s_aw_addr/len from g; s_aw_id={g,m_aw_id[g]}; m_aw_ready[g]=s_aw_ready.
//   Other masters see ready=0.
//   On s_aw handshake: cnt<=m_aw_len[g]; go to DATA.
//   If m_aw_valid[g] drops before the handshake (illegal), hold in ADDR.
//  DATA: s_w_valid=m_w_valid[g]; data/strb pass through from g; m_w_ready[g]=s_w_ready; s_w_last=(cnt==0).
//   Each W handshake with cnt!=0: cnt<=cnt-1.
//   Handshake with cnt==0: go to RESP.
//   m_w_last[g]!=(cnt==0) on a handshake pulses proto_err_o. The counter stays authoritative.
//  RESP: s_b_ready=m_b_ready[g]; m_b_valid[g]=s_b_valid; m_b_resp/m_b_id from s_b.
//   On handshake: last_grant<=g; go to IDLE.
//   Any other state with s_b_valid=1, or s_b_id[SLV_ID_W-1:ID_W]!=g, pulses proto_err_o. B still routes to g.
//  Throughput: minimum AW-to-AW spacing is len+4 cycles (arb, AW, W beats, B).
//  Fairness: after master k is served, k has lowest priority. With N masters all requesting, each waits at most N-1 bursts.
//  Simultaneous requests in IDLE are resolved only by the RR pointer. Requests arriving during a burst wait; none are dropped.
//  Reset mid-burst: the next edge returns to IDLE with all handshake outputs 0. No beat or response is replayed.
//   The slave must be reset together with the arbiter.
//  All outputs are combinational from registered state and muxed inputs. No comb path from m_*_valid to s_*_ready.
// STRUCTURE
//  Package axi_arb_pkg: wr_state_e enum {IDLE,ADDR,DATA,RESP}, localparam IDX_W=$clog2(NB_MASTER), function rr_next.
//  Sub-module rr_pick: req[NB_MASTER], last[IDX_W] -> gnt_idx, gnt_valid. Combinational, reusable by a read arbiter.
//  Top holds the FSM, counters and muxes.
// TESTING
//  1. Single master 0, len=3, slave always ready: s_aw_id=={1'b0,id}; 4 W beats; s_w_last only on beat 4; m_b_valid[0] one cycle.
//  2. Both masters request every cycle: grants alternate 0,1,0,1 over 4 bursts; each s_aw_id MSB matches the grant.
//  3. Master 1 asserts m_w_last on beat 2 of a len=3 burst: proto_err_o=1 for 1 cycle; s_w_last still on beat 4; FSM completes.
//  4. rst=1 during DATA, beat 2: next cycle busy_o=0, all m_*_ready/s_*_valid=0; first grant after release goes to master 0.
//  5. Slave stalls (s_aw_ready=0 for 5 cycles, then s_w_ready toggling, s_b_valid delayed 7 cycles): no beat lost or duplicated; master 1 ready stays 0 throughout.
//  6. s_b_valid asserted in IDLE: proto_err_o pulse, no m_b_valid.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI write (and future read) arbiters.
package axi_arb_pkg;

    // Burst life cycle: arbitrate, pass AW, stream W beats, return B.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wr_state_e;

    localparam int NB_MASTER_DEF = 2;
    localparam int IDX_W         = $clog2(NB_MASTER_DEF);

    // Index width for a pool of n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Successor of idx on a ring of n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/axi_wr_arbiter_rr_pick.sv
// Round-robin picker: first requester after 'last' in ring order.
// Purely combinational so the read arbiter can reuse it unchanged.
module rr_pick
    import axi_arb_pkg::*;
#(
    parameter int NB_MASTER = 2,
    parameter int GNT_W     = idx_width(NB_MASTER)
) (
    input  logic [NB_MASTER-1:0] req,
    input  logic [GNT_W-1:0]     last,
    output logic [GNT_W-1:0]     gnt_idx,
    output logic                 gnt_valid
);

    // Walk the ring starting just after last; the first hit wins, so last itself is checked last.
    always_comb begin
        int cand;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = int'(last);
        for (int i = 0; i < NB_MASTER; i++) begin
            cand = rr_next(cand, NB_MASTER);
            if (req[cand] && !gnt_valid) begin
                gnt_idx   = GNT_W'(cand);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin AXI write arbiter: NB_MASTER masters share one slave port,
// one burst in flight from AW grant to B handshake.
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both 1; valid never waits on ready, and no s_*_ready
// output depends combinationally on any m_*_valid input.
module axi_wr_arbiter
    import axi_arb_pkg::*;
#(
    parameter  int NB_MASTER = 2,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 64,
    parameter  int ID_W      = 1,
    localparam int GNT_W     = idx_width(NB_MASTER),
    localparam int SLV_ID_W  = ID_W + GNT_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NB_MASTER-1:0]                m_aw_valid,
    output logic [NB_MASTER-1:0]                m_aw_ready,
    input  logic [NB_MASTER-1:0][ADDR_W-1:0]    m_aw_addr,
    input  logic [NB_MASTER-1:0][7:0]           m_aw_len,
    input  logic [NB_MASTER-1:0][ID_W-1:0]      m_aw_id,
    input  logic [NB_MASTER-1:0]                m_w_valid,
    output logic [NB_MASTER-1:0]                m_w_ready,
    input  logic [NB_MASTER-1:0]                m_w_last,
    input  logic [NB_MASTER-1:0][DATA_W-1:0]    m_w_data,
    input  logic [NB_MASTER-1:0][DATA_W/8-1:0]  m_w_strb,
    output logic [NB_MASTER-1:0]                m_b_valid,
    input  logic [NB_MASTER-1:0]                m_b_ready,
    output logic [1:0]                          m_b_resp,
    output logic [ID_W-1:0]                     m_b_id,
    output logic                                s_aw_valid,
    input  logic                                s_aw_ready,
    output logic [ADDR_W-1:0]                   s_aw_addr,
    output logic [7:0]                          s_aw_len,
    output logic [SLV_ID_W-1:0]                 s_aw_id,
    output logic                                s_w_valid,
    input  logic                                s_w_ready,
    output logic [DATA_W-1:0]                   s_w_data,
    output logic [DATA_W/8-1:0]                 s_w_strb,
    output logic                                s_w_last,
    input  logic                                s_b_valid,
    output logic                                s_b_ready,
    input  logic [1:0]                          s_b_resp,
    input  logic [SLV_ID_W-1:0]                 s_b_id,
    output logic                                busy_o,
    output logic                                proto_err_o,
    output wr_state_e                           state_o
);

    wr_state_e        state;
    logic [GNT_W-1:0] g;
    logic [GNT_W-1:0] last_grant;
    logic [7:0]       cnt;
    logic [GNT_W-1:0] pick_idx;
    logic             pick_valid;
    logic             aw_hs;
    logic             w_hs;
    logic             b_hs;
    logic             err_next;

    rr_pick #(
        .NB_MASTER (NB_MASTER),
        .GNT_W     (GNT_W)
    ) u_pick (
        .req       (m_aw_valid),
        .last      (last_grant),
        .gnt_idx   (pick_idx),
        .gnt_valid (pick_valid)
    );

    // Route the granted master to the slave; only the current phase's handshake is opened.
    always_comb begin
        m_aw_ready = '0;
        m_w_ready  = '0;
        m_b_valid  = '0;
        s_aw_valid = 1'b0;
        s_w_valid  = 1'b0;
        s_b_ready  = 1'b0;
        s_aw_addr  = m_aw_addr[g];
        s_aw_len   = m_aw_len[g];
        s_aw_id    = {g, m_aw_id[g]};
        s_w_data   = m_w_data[g];
        s_w_strb   = m_w_strb[g];
        s_w_last   = (state == DATA) && (cnt == 8'd0);
        m_b_resp   = s_b_resp;
        m_b_id     = s_b_id[ID_W-1:0];
        case (state)
            ADDR: begin
                s_aw_valid    = m_aw_valid[g];
                m_aw_ready[g] = s_aw_ready;
            end
            DATA: begin
                s_w_valid    = m_w_valid[g];
                m_w_ready[g] = s_w_ready;
            end
            RESP: begin
                s_b_ready    = m_b_ready[g];
                m_b_valid[g] = s_b_valid;
            end
            default: ;
        endcase
    end

    assign aw_hs = s_aw_valid & s_aw_ready;
    assign w_hs  = s_w_valid & s_w_ready;
    assign b_hs  = s_b_valid & s_b_ready;

    // A violation is flagged but never alters routing: the beat counter and g stay authoritative.
    always_comb begin
        err_next = 1'b0;
        if (w_hs && (m_w_last[g] != (cnt == 8'd0))) begin
            err_next = 1'b1;
        end
        if (s_b_valid && (state != RESP)) begin
            err_next = 1'b1;
        end
        if (s_b_valid && (state == RESP) && (s_b_id[SLV_ID_W-1:ID_W] != g)) begin
            err_next = 1'b1;
        end
    end

    // Burst sequencer: grant, address, counted data beats, response, then hand the pointer on.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            g           <= '0;
            last_grant  <= GNT_W'(NB_MASTER - 1);
            cnt         <= 8'd0;
            proto_err_o <= 1'b0;
        end else begin
            proto_err_o <= err_next;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        g     <= pick_idx;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (aw_hs) begin
                        cnt   <= m_aw_len[g];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        if (cnt == 8'd0) begin
                            state <= RESP;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        last_grant <= g;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o  = (state != IDLE);
    assign state_o = state;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: bench-side masters and slave, burst order
// predicted by a round-robin model over pending-burst counts.
module tb_axi_wr_arbiter;
    import axi_arb_pkg::*;

    localparam int NB  = 2;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int SW  = DW / 8;
    localparam int IW  = 1;
    localparam int XW  = 1;
    localparam int SIW = IW + XW;

    logic                      clk;
    logic                      rst;
    logic [NB-1:0]             m_aw_valid;
    logic [NB-1:0]             m_aw_ready;
    logic [NB-1:0][AW-1:0]     m_aw_addr;
    logic [NB-1:0][7:0]        m_aw_len;
    logic [NB-1:0][IW-1:0]     m_aw_id;
    logic [NB-1:0]             m_w_valid;
    logic [NB-1:0]             m_w_ready;
    logic [NB-1:0]             m_w_last;
    logic [NB-1:0][DW-1:0]     m_w_data;
    logic [NB-1:0][SW-1:0]     m_w_strb;
    logic [NB-1:0]             m_b_valid;
    logic [NB-1:0]             m_b_ready;
    logic [1:0]                m_b_resp;
    logic [IW-1:0]             m_b_id;
    logic                      s_aw_valid;
    logic                      s_aw_ready;
    logic [AW-1:0]             s_aw_addr;
    logic [7:0]                s_aw_len;
    logic [SIW-1:0]            s_aw_id;
    logic                      s_w_valid;
    logic                      s_w_ready;
    logic [DW-1:0]             s_w_data;
    logic [SW-1:0]             s_w_strb;
    logic                      s_w_last;
    logic                      s_b_valid;
    logic                      s_b_ready;
    logic [1:0]                s_b_resp;
    logic [SIW-1:0]            s_b_id;
    logic                      busy_o;
    logic                      proto_err_o;
    wr_state_e                 state_o;

    axi_wr_arbiter #(
        .NB_MASTER (NB),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .ID_W      (IW)
    ) dut (
        .clk (clk), .rst (rst),
        .m_aw_valid (m_aw_valid), .m_aw_ready (m_aw_ready), .m_aw_addr (m_aw_addr),
        .m_aw_len (m_aw_len), .m_aw_id (m_aw_id),
        .m_w_valid (m_w_valid), .m_w_ready (m_w_ready), .m_w_last (m_w_last),
        .m_w_data (m_w_data), .m_w_strb (m_w_strb),
        .m_b_valid (m_b_valid), .m_b_ready (m_b_ready), .m_b_resp (m_b_resp), .m_b_id (m_b_id),
        .s_aw_valid (s_aw_valid), .s_aw_ready (s_aw_ready), .s_aw_addr (s_aw_addr),
        .s_aw_len (s_aw_len), .s_aw_id (s_aw_id),
        .s_w_valid (s_w_valid), .s_w_ready (s_w_ready), .s_w_data (s_w_data),
        .s_w_strb (s_w_strb), .s_w_last (s_w_last),
        .s_b_valid (s_b_valid), .s_b_ready (s_b_ready), .s_b_resp (s_b_resp), .s_b_id (s_b_id),
        .busy_o (busy_o), .proto_err_o (proto_err_o), .state_o (state_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Master-side burst queues (one entry per burst, data/strb one entry per beat).
    int             mq_len  [NB][$];
    logic [AW-1:0]  mq_addr [NB][$];
    logic [IW-1:0]  mq_id   [NB][$];
    int             mq_bad  [NB][$];
    logic [DW-1:0]  mq_data [NB][$];
    logic [SW-1:0]  mq_strb [NB][$];
    int m_phase [NB];
    int m_beat  [NB];
    int m_cur_len [NB];
    int m_cur_bad [NB];

    // Scoreboard: expected slave-side traffic in predicted grant order.
    logic [SIW+8+AW-1:0] exp_aw_q[$];
    logic [SW+DW:0]      exp_w_q[$];
    int                  exp_m_q[$];
    int                  model_last;

    // Slave behaviour knobs and state.
    int         aw_stall_cfg, aw_stall_left, b_delay, b_cnt, b_vcyc;
    bit         w_toggle, w_tog, m_rand, s_rand, b_pend, b_act;
    logic [1:0] b_resp_d;
    logic [SIW-1:0] b_id_d;

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        m_aw_valid = '0; m_aw_addr = '0; m_aw_len = '0; m_aw_id = '0;
        m_w_valid = '0; m_w_last = '0; m_w_data = '0; m_w_strb = '0; m_b_ready = '0;
        s_aw_ready = 1'b0; s_w_ready = 1'b0; s_b_valid = 1'b0; s_b_resp = 2'b00; s_b_id = '0;
    endtask

    task automatic tb_clear();
        for (int m = 0; m < NB; m++) begin
            mq_len[m].delete(); mq_addr[m].delete(); mq_id[m].delete();
            mq_bad[m].delete(); mq_data[m].delete(); mq_strb[m].delete();
            m_phase[m] = 0; m_beat[m] = 0; m_cur_len[m] = 0; m_cur_bad[m] = -1;
        end
        exp_aw_q.delete(); exp_w_q.delete(); exp_m_q.delete();
        b_pend = 1'b0; b_act = 1'b0; b_cnt = 0; b_resp_d = 2'b00; b_id_d = '0;
        aw_stall_left = aw_stall_cfg; w_tog = 1'b0;
    endtask

    task automatic cfg(input int stall, input bit tog, input int bdel, input bit mr, input bit sr);
        aw_stall_cfg = stall; aw_stall_left = stall; w_toggle = tog;
        b_delay = bdel; m_rand = mr; s_rand = sr;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_last = NB - 1;
        tb_clear();
    endtask

    task automatic add_burst(input int m, input int len, input int bad);
        mq_len[m].push_back(len);
        mq_addr[m].push_back($urandom);
        mq_id[m].push_back(IW'($urandom_range(0, (1 << IW) - 1)));
        mq_bad[m].push_back(bad);
        for (int b = 0; b <= len; b++) begin
            mq_data[m].push_back({$urandom, $urandom});
            mq_strb[m].push_back(SW'($urandom));
        end
    endtask

    // Reference model: every master with bursts left keeps requesting, so each
    // grant is the first pending master after the previous one, ring order.
    task automatic build_expect();
        int left [NB];
        int pos  [NB];
        int off  [NB];
        int total;
        int last;
        int k;
        int len;
        total = 0;
        for (int m = 0; m < NB; m++) begin
            left[m] = mq_len[m].size(); pos[m] = 0; off[m] = 0; total += left[m];
        end
        last = model_last;
        for (int n = 0; n < total; n++) begin
            k = -1;
            for (int i = 1; i <= NB; i++) begin
                if (k < 0 && left[(last + i) % NB] > 0) k = (last + i) % NB;
            end
            len = mq_len[k][pos[k]];
            exp_m_q.push_back(k);
            exp_aw_q.push_back({XW'(k), mq_id[k][pos[k]], 8'(len), mq_addr[k][pos[k]]});
            for (int b = 0; b <= len; b++) begin
                exp_w_q.push_back({(b == len), mq_strb[k][off[k] + b], mq_data[k][off[k] + b]});
            end
            off[k] += len + 1; pos[k]++; left[k]--; last = k;
        end
        model_last = last;
    endtask

    // Cycle engine: bench masters and slave act each cycle, scoreboard checks each handshake.
    task automatic run_traffic(input string tag, input int max_cycles, input int stop_w,
                               input bit chk_space, input int exp_perr);
        int  w_seen = 0;
        int  done = 0;
        int  total;
        int  perr = 0;
        int  cur;
        int  last_aw_cyc = -1;
        int  last_aw_len = 0;
        bit  leak = 1'b0;
        logic [SIW+8+AW-1:0] ea;
        logic [SW+DW:0]      ew;
        total = exp_m_q.size();
        b_vcyc = 0;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            @(posedge clk);
            #1;
            for (int m = 0; m < NB; m++) begin
                m_aw_valid[m] = (m_phase[m] == 0) && (mq_len[m].size() > 0);
                if (mq_len[m].size() > 0) begin
                    m_aw_addr[m] = mq_addr[m][0];
                    m_aw_len[m]  = 8'(mq_len[m][0]);
                    m_aw_id[m]   = mq_id[m][0];
                end
                m_w_valid[m] = (m_phase[m] == 1) && (!m_rand || $urandom_range(0, 3) != 0);
                m_w_last[m]  = 1'b0;
                if (m_phase[m] == 1) begin
                    m_w_data[m] = mq_data[m][0];
                    m_w_strb[m] = mq_strb[m][0];
                    m_w_last[m] = (m_beat[m] == m_cur_len[m]) ^ (m_beat[m] == m_cur_bad[m]);
                end
                m_b_ready[m] = (m_phase[m] == 2) && (!m_rand || $urandom_range(0, 1) == 1);
            end
            s_aw_ready = (aw_stall_left == 0);
            s_w_ready  = w_toggle ? w_tog : (s_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
            w_tog = ~w_tog;
            if (b_pend) begin
                if (b_cnt == 0) begin
                    b_pend = 1'b0; b_act = 1'b1; b_resp_d = 2'($urandom_range(0, 3));
                end else begin
                    b_cnt--;
                end
            end
            s_b_valid = b_act; s_b_resp = b_resp_d; s_b_id = b_id_d;
            #1;
            if (proto_err_o === 1'b1) perr++;
            if (m_b_valid !== '0) b_vcyc++;
            cur = (exp_m_q.size() > 0) ? exp_m_q[0] : -1;
            for (int m = 0; m < NB; m++) begin
                if (m != cur && (m_aw_ready[m] !== 1'b0 || m_w_ready[m] !== 1'b0 || m_b_valid[m] !== 1'b0))
                    leak = 1'b1;
            end
            // slave AW
            if (s_aw_valid && s_aw_ready) begin
                ea = (exp_aw_q.size() > 0) ? exp_aw_q[0] : 'x;
                checks++;
                if ({s_aw_id, s_aw_len, s_aw_addr} !== ea) begin
                    errors++;
                    $display("FAIL %s aw: got %h want %h", tag, {s_aw_id, s_aw_len, s_aw_addr}, ea);
                end
                if (chk_space && last_aw_cyc >= 0) begin
                    checks++;
                    if (cyc - last_aw_cyc != last_aw_len + 4) begin
                        errors++;
                        $display("FAIL %s aw_spacing: got %0d want %0d", tag, cyc - last_aw_cyc, last_aw_len + 4);
                    end
                end
                last_aw_cyc = cyc;
                last_aw_len = int'(ea[AW+7:AW]);
                if (exp_aw_q.size() > 0) ea = exp_aw_q.pop_front();
                b_id_d = ea[SIW+8+AW-1:8+AW];
                aw_stall_left = aw_stall_cfg;
            end else if (s_aw_valid && aw_stall_left > 0) begin
                aw_stall_left--;
            end
            // slave W
            if (s_w_valid && s_w_ready) begin
                w_seen++;
                ew = (exp_w_q.size() > 0) ? exp_w_q[0] : 'x;
                checks++;
                if ({s_w_last, s_w_strb, s_w_data} !== ew) begin
                    errors++;
                    $display("FAIL %s w_beat %0d: got %h want %h", tag, w_seen, {s_w_last, s_w_strb, s_w_data}, ew);
                end
                if (exp_w_q.size() > 0) ew = exp_w_q.pop_front();
                if (ew[SW+DW] === 1'b1) begin
                    b_pend = 1'b1; b_cnt = b_delay;
                end
            end
            if (s_b_valid && s_b_ready) b_act = 1'b0;
            // master side
            for (int m = 0; m < NB; m++) begin
                if (m_aw_valid[m] && m_aw_ready[m]) begin
                    m_cur_len[m] = mq_len[m].pop_front();
                    m_cur_bad[m] = mq_bad[m].pop_front();
                    void'(mq_addr[m].pop_front());
                    void'(mq_id[m].pop_front());
                    m_phase[m] = 1; m_beat[m] = 0;
                end else if (m_w_valid[m] && m_w_ready[m]) begin
                    void'(mq_data[m].pop_front());
                    void'(mq_strb[m].pop_front());
                    if (m_beat[m] == m_cur_len[m]) m_phase[m] = 2;
                    m_beat[m]++;
                end else if (m_b_valid[m] && m_b_ready[m]) begin
                    checks++;
                    if (m != cur || m_b_resp !== b_resp_d || m_b_id !== b_id_d[IW-1:0]) begin
                        errors++;
                        $display("FAIL %s b_route: got m%0d resp %0d id %0d want m%0d resp %0d id %0d",
                                 tag, m, m_b_resp, m_b_id, cur, b_resp_d, b_id_d[IW-1:0]);
                    end
                    m_phase[m] = 0;
                    done++;
                    if (exp_m_q.size() > 0) void'(exp_m_q.pop_front());
                end
            end
            if (done == total) break;
            if (stop_w > 0 && w_seen >= stop_w) break;
        end
        @(posedge clk);
        #1;
        idle_inputs();
        checks++;
        if (leak) begin
            errors++;
            $display("FAIL %s non_granted_leak: got 1 want 0", tag);
        end
        if (stop_w == 0) begin
            checks++;
            if (done != total) begin
                errors++;
                $display("FAIL %s completion: got %0d bursts want %0d (cycle budget expired)", tag, done, total);
            end
            checks++;
            if (perr != exp_perr) begin
                errors++;
                $display("FAIL %s proto_err_cycles: got %0d want %0d", tag, perr, exp_perr);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        m_aw_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy_o, proto_err_o, m_aw_ready, m_w_ready, m_b_valid, s_aw_valid, s_w_valid, s_b_ready} !== '0
            || state_o !== IDLE) begin
            errors++;
            $display("FAIL reset_outputs: got busy %b err %b state %0d want all 0", busy_o, proto_err_o, state_o);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (m_aw_ready !== '0 || s_aw_valid !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_comb_grant: got aw_ready %b s_aw_valid %b want 0", m_aw_ready, s_aw_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b1 || s_aw_valid !== 1'b1 || s_aw_id[SIW-1] !== 1'b0 || m_aw_ready !== '0) begin
            errors++;
            $display("FAIL first_grant: got busy %b s_aw_valid %b idx %b aw_ready %b want 1 1 0 00",
                     busy_o, s_aw_valid, s_aw_id[SIW-1], m_aw_ready);
        end
        s_aw_ready = 1'b1;
        #1;
        checks++;
        if (m_aw_ready !== 2'b01) begin
            errors++;
            $display("FAIL aw_ready_route: got %b want 01", m_aw_ready);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        cfg(0, 1'b0, 0, 1'b0, 1'b0);
        add_burst(0, 3, -1);
        build_expect();
        run_traffic("single", 100, 0, 1'b0, 0);
        checks++;
        if (b_vcyc != 1) begin
            errors++;
            $display("FAIL single b_valid_cycles: got %0d want 1", b_vcyc);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cfg(0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            add_burst(0, $urandom_range(0, 3), -1);
            add_burst(1, $urandom_range(0, 3), -1);
        end
        build_expect();
        run_traffic("alternate", 200, 0, 1'b1, 0);
    endtask

    task automatic test_bad_last();
        do_reset();
        cfg(0, 1'b0, 0, 1'b0, 1'b0);
        add_burst(1, 3, 1);
        build_expect();
        run_traffic("bad_last", 100, 0, 1'b0, 1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        cfg(0, 1'b0, 0, 1'b0, 1'b0);
        add_burst(0, 1, -1);
        add_burst(1, 3, -1);
        build_expect();
        run_traffic("pre_reset", 100, 4, 1'b0, 0);
        rst = 1'b1;
        m_aw_valid = '1; m_w_valid = '1; m_b_ready = '1;
        s_aw_ready = 1'b1; s_w_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy_o, m_aw_ready, m_w_ready, m_b_valid, s_aw_valid, s_w_valid, s_b_ready} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got busy %b aw_rdy %b w_rdy %b s_w_valid %b want 0",
                     busy_o, m_aw_ready, m_w_ready, s_w_valid);
        end
        rst = 1'b0;
        idle_inputs();
        model_last = NB - 1;
        tb_clear();
        add_burst(1, 0, -1);
        add_burst(0, 0, -1);
        build_expect();
        run_traffic("post_reset", 100, 0, 1'b0, 0);
    endtask

    task automatic test_stall();
        do_reset();
        cfg(5, 1'b1, 7, 1'b0, 1'b0);
        add_burst(0, $urandom_range(1, 4), -1);
        add_burst(0, $urandom_range(1, 4), -1);
        build_expect();
        run_traffic("stall", 300, 0, 1'b0, 0);
    endtask

    task automatic test_b_idle();
        do_reset();
        @(posedge clk);
        #1;
        s_b_valid = 1'b1;
        s_b_id = '0;
        #1;
        checks++;
        if (m_b_valid !== '0) begin
            errors++;
            $display("FAIL b_idle_route: got %b want 00", m_b_valid);
        end
        @(posedge clk);
        #1;
        s_b_valid = 1'b0;
        checks++;
        if (proto_err_o !== 1'b1) begin
            errors++;
            $display("FAIL b_idle_err_pulse: got %b want 1", proto_err_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (proto_err_o !== 1'b0) begin
            errors++;
            $display("FAIL b_idle_err_width: got %b want 0", proto_err_o);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            do_reset();
            cfg($urandom_range(0, 2), 1'b0, $urandom_range(0, 3), 1'b1, 1'b1);
            for (int m = 0; m < NB; m++) begin
                for (int n = $urandom_range(1, 4); n > 0; n--) add_burst(m, $urandom_range(0, 7), -1);
            end
            build_expect();
            run_traffic("random", 3000, 0, 1'b0, 0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        idle_inputs();
        cfg(0, 1'b0, 0, 1'b0, 1'b0);
        model_last = NB - 1;
        tb_clear();
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_last();
        test_reset_mid();
        test_stall();
        test_b_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
